// File: rtl/tail_light_ctrl_if.sv
// Lamp-request and lamp-drive signals shared between the switch/debounce
// logic (master) and the tail-light sequencer (slave).
interface tail_light_ctrl_if;
  logic       left_req;
  logic       right_req;
  logic       hazard_req;
  logic       brake;
  logic [2:0] left_light;
  logic [2:0] right_light;
  logic       busy;

  modport master (
    output left_req, right_req, hazard_req, brake,
    input  left_light, right_light, busy
  );

  modport slave (
    input  left_req, right_req, hazard_req, brake,
    output left_light, right_light, busy
  );
endinterface

// File: rtl/tail_light_ctrl.sv
// Tail-light sequencer: arbitrates turn/hazard requests, steps the active
// bank(s) through 001-011-111-000 every TICK_DIV cycles, overlays brake.
module tail_light_ctrl #(
  parameter int TICK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  tail_light_ctrl_if.slave  bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } mode_t;

  mode_t         mode;
  mode_t         req_mode;
  logic [1:0]    step;
  logic [PW-1:0] prescaler;
  logic          tick;
  logic [2:0]    pattern;
  logic [2:0]    brake_val;

  assign tick = (prescaler == PW'(TICK_DIV - 1));

  // Both turn switches at once is treated as a hazard request.
  always_comb begin
    req_mode = IDLE;
    if (bus.hazard_req || (bus.left_req && bus.right_req))
      req_mode = HAZARD;
    else if (bus.left_req)
      req_mode = LEFT;
    else if (bus.right_req)
      req_mode = RIGHT;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode      <= IDLE;
      step      <= 2'd0;
      prescaler <= '0;
    end else begin
      case (mode)
        IDLE: begin
          prescaler <= '0;
          step      <= 2'd0;
          mode      <= req_mode;
        end
        LEFT, RIGHT, HAZARD: begin
          // Hazard preempts a turn sequence immediately; everything else
          // waits for the end of the current sequence.
          if (mode != HAZARD && req_mode == HAZARD) begin
            mode      <= HAZARD;
            step      <= 2'd0;
            prescaler <= '0;
          end else if (tick) begin
            prescaler <= '0;
            if (step == 2'd3) begin
              mode <= req_mode;
              step <= 2'd0;
            end else begin
              step <= step + 2'd1;
            end
          end else begin
            prescaler <= prescaler + PW'(1);
          end
        end
        default: begin
          mode      <= IDLE;
          step      <= 2'd0;
          prescaler <= '0;
        end
      endcase
    end
  end

  always_comb begin
    case (step)
      2'd0:    pattern = 3'b001;
      2'd1:    pattern = 3'b011;
      2'd2:    pattern = 3'b111;
      default: pattern = 3'b000;
    endcase
  end

  assign brake_val = bus.brake ? 3'b111 : 3'b000;

  assign bus.left_light  = (mode == LEFT  || mode == HAZARD) ? pattern : brake_val;
  assign bus.right_light = (mode == RIGHT || mode == HAZARD) ? pattern : brake_val;
  assign bus.busy        = (mode != IDLE);

endmodule

// File: tb/tb_tail_light_ctrl.sv
// Scoreboard bench for tail_light_ctrl: one instance at TICK_DIV=4, one at
// TICK_DIV=1, expected lamp states queued per cycle from the sequence timing.
module tb_tail_light_ctrl;

  typedef struct {
    logic [2:0] l;
    logic [2:0] r;
    logic       b;
  } exp_t;

  logic clk;
  logic reset4_n;
  logic reset1_n;
  int   checks;
  int   fails;
  exp_t exp_q[$];

  tail_light_ctrl_if bus4 ();
  tail_light_ctrl_if bus1 ();

  tail_light_ctrl #(.TICK_DIV(4)) dut4 (.clk(clk), .reset_n(reset4_n), .bus(bus4));
  tail_light_ctrl #(.TICK_DIV(1)) dut1 (.clk(clk), .reset_n(reset1_n), .bus(bus1));

  always #5 clk = ~clk;

  function automatic logic [2:0] pat(int s);
    case (s % 4)
      0:       return 3'b001;
      1:       return 3'b011;
      2:       return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] brk(logic b);
    return b ? 3'b111 : 3'b000;
  endfunction

  task automatic test_reset();
    $display("[TB] test_reset");
    #1;
    checks++;
    if ({bus4.left_light, bus4.right_light, bus4.busy} !== 7'b000_000_0) begin
      fails++;
      $display("[TB] FAIL reset_idle: got L=%b R=%b busy=%b, expected L=000 R=000 busy=0",
               bus4.left_light, bus4.right_light, bus4.busy);
    end
    bus4.brake = 1'b1;
    #1;
    checks++;
    if ({bus4.left_light, bus4.right_light, bus4.busy} !== 7'b111_111_0) begin
      fails++;
      $display("[TB] FAIL reset_brake: got L=%b R=%b busy=%b, expected L=111 R=111 busy=0",
               bus4.left_light, bus4.right_light, bus4.busy);
    end
    bus4.brake = 1'b0;
    @(negedge clk);
    reset4_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus4.left_light, bus4.right_light, bus4.busy} !== 7'b000_000_0) begin
      fails++;
      $display("[TB] FAIL idle_after_release: got L=%b R=%b busy=%b, expected L=000 R=000 busy=0",
               bus4.left_light, bus4.right_light, bus4.busy);
    end
  endtask

  task automatic test_left_held();
    exp_t e;
    logic b;
    $display("[TB] test_left_held");
    @(posedge clk); #1;
    bus4.left_req = 1'b1;
    for (int c = 0; c < 36; c++) begin
      @(posedge clk); #1;
      b = (c >= 20 && c < 26);
      bus4.brake    = b;
      bus4.left_req = (c < 31);
      if (c < 32) exp_q.push_back('{pat(c / 4), brk(b), 1'b1});
      else        exp_q.push_back('{3'b000, brk(b), 1'b0});
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({bus4.left_light, bus4.right_light, bus4.busy} !== {e.l, e.r, e.b}) begin
        fails++;
        $display("[TB] FAIL left_held cyc %0d: got L=%b R=%b busy=%b, expected L=%b R=%b busy=%b",
                 c, bus4.left_light, bus4.right_light, bus4.busy, e.l, e.r, e.b);
      end
    end
    bus4.brake = 1'b0;
  endtask

  task automatic test_right_pulse();
    exp_t e;
    $display("[TB] test_right_pulse");
    @(posedge clk); #1;
    bus4.right_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      bus4.right_req = 1'b0;
      if (c < 16) exp_q.push_back('{3'b000, pat(c / 4), 1'b1});
      else        exp_q.push_back('{3'b000, 3'b000, 1'b0});
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({bus4.left_light, bus4.right_light, bus4.busy} !== {e.l, e.r, e.b}) begin
        fails++;
        $display("[TB] FAIL right_pulse cyc %0d: got L=%b R=%b busy=%b, expected L=%b R=%b busy=%b",
                 c, bus4.left_light, bus4.right_light, bus4.busy, e.l, e.r, e.b);
      end
    end
  endtask

  task automatic test_hazard_preempt();
    exp_t e;
    logic b;
    $display("[TB] test_hazard_preempt");
    @(posedge clk); #1;
    bus4.left_req = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      b = c[0];
      bus4.brake      = b;
      bus4.left_req   = (c < 20);
      bus4.hazard_req = (c >= 4 && c < 20);
      if (c < 5)       exp_q.push_back('{pat(c / 4), brk(b), 1'b1});
      else if (c < 21) exp_q.push_back('{pat((c - 5) / 4), pat((c - 5) / 4), 1'b1});
      else             exp_q.push_back('{brk(b), brk(b), 1'b0});
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({bus4.left_light, bus4.right_light, bus4.busy} !== {e.l, e.r, e.b}) begin
        fails++;
        $display("[TB] FAIL hazard_preempt cyc %0d: got L=%b R=%b busy=%b, expected L=%b R=%b busy=%b",
                 c, bus4.left_light, bus4.right_light, bus4.busy, e.l, e.r, e.b);
      end
    end
    bus4.brake = 1'b0;
  endtask

  task automatic test_left_to_right();
    exp_t e;
    $display("[TB] test_left_to_right");
    @(posedge clk); #1;
    bus4.left_req = 1'b1;
    for (int c = 0; c < 36; c++) begin
      @(posedge clk); #1;
      bus4.left_req  = (c < 4);
      bus4.right_req = (c >= 4 && c < 31);
      if (c < 16)      exp_q.push_back('{pat(c / 4), 3'b000, 1'b1});
      else if (c < 32) exp_q.push_back('{3'b000, pat((c - 16) / 4), 1'b1});
      else             exp_q.push_back('{3'b000, 3'b000, 1'b0});
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({bus4.left_light, bus4.right_light, bus4.busy} !== {e.l, e.r, e.b}) begin
        fails++;
        $display("[TB] FAIL left_to_right cyc %0d: got L=%b R=%b busy=%b, expected L=%b R=%b busy=%b",
                 c, bus4.left_light, bus4.right_light, bus4.busy, e.l, e.r, e.b);
      end
    end
  endtask

  task automatic test_tick1_reset();
    exp_t e;
    $display("[TB] test_tick1_reset");
    @(negedge clk);
    reset1_n = 1'b1;
    @(posedge clk); #1;
    bus1.left_req  = 1'b1;
    bus1.right_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      exp_q.push_back('{pat(c), pat(c), 1'b1});
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({bus1.left_light, bus1.right_light, bus1.busy} !== {e.l, e.r, e.b}) begin
        fails++;
        $display("[TB] FAIL tick1_both cyc %0d: got L=%b R=%b busy=%b, expected L=%b R=%b busy=%b",
                 c, bus1.left_light, bus1.right_light, bus1.busy, e.l, e.r, e.b);
      end
    end
    // Mid-cycle reset: outputs must drop before the next clock edge.
    #1;
    reset1_n = 1'b0;
    #1;
    checks++;
    if ({bus1.left_light, bus1.right_light, bus1.busy} !== 7'b000_000_0) begin
      fails++;
      $display("[TB] FAIL tick1_async_reset: got L=%b R=%b busy=%b, expected L=000 R=000 busy=0",
               bus1.left_light, bus1.right_light, bus1.busy);
    end
    bus1.brake = 1'b1;
    #1;
    checks++;
    if ({bus1.left_light, bus1.right_light, bus1.busy} !== 7'b111_111_0) begin
      fails++;
      $display("[TB] FAIL tick1_reset_brake: got L=%b R=%b busy=%b, expected L=111 R=111 busy=0",
               bus1.left_light, bus1.right_light, bus1.busy);
    end
    bus1.brake     = 1'b0;
    bus1.left_req  = 1'b0;
    bus1.right_req = 1'b0;
    @(negedge clk);
    reset1_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus1.left_light, bus1.right_light, bus1.busy} !== 7'b000_000_0) begin
      fails++;
      $display("[TB] FAIL tick1_no_resume: got L=%b R=%b busy=%b, expected L=000 R=000 busy=0",
               bus1.left_light, bus1.right_light, bus1.busy);
    end
  endtask

  initial begin
    clk             = 1'b0;
    reset4_n        = 1'b0;
    reset1_n        = 1'b0;
    checks          = 0;
    fails           = 0;
    bus4.left_req   = 1'b0;
    bus4.right_req  = 1'b0;
    bus4.hazard_req = 1'b0;
    bus4.brake      = 1'b0;
    bus1.left_req   = 1'b0;
    bus1.right_req  = 1'b0;
    bus1.hazard_req = 1'b0;
    bus1.brake      = 1'b0;

    test_reset();
    test_left_held();
    test_right_pulse();
    test_hazard_preempt();
    test_left_to_right();
    test_tick1_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
